// File: rtl/mb_clk_gate_ctrl_if.sv
// Mainband clock-gate control bundle: ungate request and idle status in,
// ICG enable and wake status out.
interface mb_clk_gate_ctrl_if;
    logic       i_clk_gate_en;
    logic       i_tx_idle;
    logic       o_mb_clk_en;
    logic       o_ltsm_is_waked_up;
    logic [1:0] o_gate_state;
    logic       o_gated;

    // master: wake handshake / datapath side; slave: the gate controller
    modport master (
        output i_clk_gate_en,
        output i_tx_idle,
        input  o_mb_clk_en,
        input  o_ltsm_is_waked_up,
        input  o_gate_state,
        input  o_gated
    );

    modport slave (
        input  i_clk_gate_en,
        input  i_tx_idle,
        output o_mb_clk_en,
        output o_ltsm_is_waked_up,
        output o_gate_state,
        output o_gated
    );
endinterface

// File: rtl/mb_clk_gate_ctrl.sv
// Mainband ICG controller: clock-settle delay before reporting awake and an
// idle-drain hysteresis before re-gating.
module mb_clk_gate_ctrl #(
    parameter int unsigned WAKE_DLY  = 4,
    parameter int unsigned SLEEP_DLY = 8,
    parameter int unsigned CNT_W     =
        $clog2(((WAKE_DLY > SLEEP_DLY) ? WAKE_DLY : SLEEP_DLY) + 1)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    mb_clk_gate_ctrl_if.slave   gate
);

    typedef enum logic [1:0] {
        GATED  = 2'b00,
        WAKE   = 2'b01,
        ACTIVE = 2'b10,
        DRAIN  = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mb_clk_en_q;
    logic               waked_q;
    logic               gated_q;
    logic [1:0]         gate_state_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            GATED: begin
                if (gate.i_clk_gate_en) begin
                    state_d = WAKE;
                    cnt_d   = '0;
                end
            end
            WAKE: begin
                if (!gate.i_clk_gate_en) begin
                    state_d = GATED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(WAKE_DLY - 1)) begin
                    state_d = ACTIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ACTIVE: begin
                if (!gate.i_clk_gate_en) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                // Clock never stopped here, so a re-request skips the settle delay
                if (gate.i_clk_gate_en) begin
                    state_d = ACTIVE;
                    cnt_d   = '0;
                end else if (!gate.i_tx_idle) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(SLEEP_DLY - 1)) begin
                    state_d = GATED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = GATED;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decode the next state so they move on the same edge as the state
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= GATED;
            cnt_q        <= '0;
            mb_clk_en_q  <= 1'b0;
            waked_q      <= 1'b0;
            gated_q      <= 1'b1;
            gate_state_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mb_clk_en_q  <= (state_d != GATED);
            waked_q      <= (state_d == ACTIVE);
            gated_q      <= (state_d == GATED);
            gate_state_q <= state_d;
        end
    end

    assign gate.o_mb_clk_en        = mb_clk_en_q;
    assign gate.o_ltsm_is_waked_up = waked_q;
    assign gate.o_gated            = gated_q;
    assign gate.o_gate_state       = gate_state_q;

endmodule
